// File: rtl/memory_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: widths, port ids, FSM states.
`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 8
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 8
`endif

package memory_arbiter_pkg;
  // Requester index encoding
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // IDLE: command register empty, ACCESS: command register drives the bank
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;
endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);
  // Grant is purely combinational from the valids and the pointer
  always_comb begin
    o_grant    = 2'b00;
    o_grant[0] = i_valid[0] & (~i_valid[1] | (i_last_grant == PORT1));
    o_grant[1] = i_valid[1] & (~i_valid[0] | (i_last_grant == PORT0));
  end
endmodule

// File: rtl/memory_arbiter.sv
// Two requesters sharing one single-port memory bank. One command accepted per
// cycle, executed in the following cycle; read data is returned one cycle later
// to the owning port, so responses stay in acceptance order.
`ifndef DATA_WORD_SIZE
`define DATA_WORD_SIZE 8
`endif
`ifndef DATA_ADDR_SIZE
`define DATA_ADDR_SIZE 8
`endif

module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int word_size = `DATA_WORD_SIZE,
  parameter int addr_size = `DATA_ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [addr_size-1:0] req0_addr,
  input  logic [word_size-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [addr_size-1:0] req1_addr,
  input  logic [word_size-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [word_size-1:0] rsp0_rdata,
  output logic                 rsp1_valid,
  output logic [word_size-1:0] rsp1_rdata,
  output logic                 mem_w_en,
  output logic [addr_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_d_in,
  input  logic [word_size-1:0] mem_d_out
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_last_grant;
  logic                 r_cmd_valid;
  logic                 r_cmd_port;
  logic                 r_cmd_we;
  logic [addr_size-1:0] r_cmd_addr;
  logic [word_size-1:0] r_cmd_wdata;
  logic                 r_rsp0_valid;
  logic                 r_rsp1_valid;
  logic [word_size-1:0] r_rsp0_rdata;
  logic [word_size-1:0] r_rsp1_rdata;

  logic [1:0]           w_grant;
  logic                 w_accept;
  logic                 w_sel;
  logic                 w_access;

  rr_arbiter2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Readies are masked by reset so nothing looks accepted while held in reset
  assign req0_ready = w_grant[0] & rst_n;
  assign req1_ready = w_grant[1] & rst_n;
  assign w_accept   = req0_ready | req1_ready;
  assign w_sel      = req1_ready ? PORT1 : PORT0;
  assign w_access   = (r_state == ST_ACCESS) & r_cmd_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: stay busy as long as a new command is accepted every cycle
  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_accept) w_state_nxt = ST_ACCESS;
  end

  // Bank drive: command register in ACCESS, quiet zeros in IDLE
  always_comb begin
    mem_w_en = 1'b0;
    mem_addr = '0;
    mem_d_in = '0;
    if (w_access) begin
      mem_w_en = r_cmd_we;
      mem_addr = r_cmd_addr;
      mem_d_in = r_cmd_wdata;
    end
  end

  // Round-robin pointer moves only when something is actually accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_grant <= PORT1;
    else if (w_accept) r_last_grant <= w_sel;
  end

  // Command register captures the accepted command; payload kept when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_port  <= PORT0;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else begin
      r_cmd_valid <= w_accept;
      if (w_accept) begin
        r_cmd_port  <= w_sel;
        r_cmd_we    <= w_sel ? req1_we    : req0_we;
        r_cmd_addr  <= w_sel ? req1_addr  : req0_addr;
        r_cmd_wdata <= w_sel ? req1_wdata : req0_wdata;
      end
    end
  end

  // Read response: register bank data for the owning port, pulse valid once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (w_access && !r_cmd_we) begin
        if (r_cmd_port == PORT1) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_rdata <= mem_d_out;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_rdata <= mem_d_out;
        end
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter word_size, default `DATA_WORD_SIZE, data width in bits.
REQ-002 SHALL have parameter addr_size, default `DATA_ADDR_SIZE, address width in bits.
REQ-003 clk  in  1  single clock; all state on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0_valid / req1_valid  in  1  requester i presents a command.
REQ-006 req0_ready / req1_ready  out  1  command i accepted this cycle (valid & ready).
REQ-007 req0_we / req1_we  in  1  1 = write, 0 = read.
REQ-008 req0_addr / req1_addr  in  addr_size  access address.
REQ-009 req0_wdata / req1_wdata  in  word_size  write data.
REQ-010 rsp0_valid / rsp1_valid  out  1  one-cycle pulse: read data for requester i available.
REQ-011 rsp0_rdata / rsp1_rdata  out  word_size  read data; holds last value when rspi_valid=0.
REQ-012 mem_w_en  out  1  to memory bank write enable.
REQ-013 mem_addr  out  addr_size  to memory bank address.
REQ-014 mem_d_in  out  word_size  to memory bank data in.
REQ-015 mem_d_out  in  word_size  combinational read data from memory bank.

Function
REQ-016 SHALL accept at most one command per cycle; readyi combinational from validi and round-robin pointer, never high without validi.
REQ-017 Arbitration: single valid -> granted; both valid -> grant the port not granted last; pointer last_grant updates only on acceptance.
REQ-018 Accepted command SHALL be captured into command register (valid, port, we, addr, wdata) at the acceptance edge.
REQ-019 State machine: IDLE (cmd register empty), ACCESS (cmd register full); IDLE->ACCESS on acceptance; ACCESS->ACCESS on new acceptance; ACCESS->IDLE otherwise.
REQ-020 In ACCESS: mem_addr = cmd addr, mem_d_in = cmd wdata, mem_w_en = cmd we; in IDLE: mem_w_en = 0, mem_addr/mem_d_in = 0.
REQ-021 Acceptance SHALL be allowed in ACCESS (one command/cycle sustained throughput, no bubble).
REQ-022 Read in ACCESS SHALL register mem_d_out into rspP_rdata and pulse rspP_valid next cycle for owning port P only; writes produce no response.
REQ-023 Latency: accept edge N -> memory access cycle N+1 -> rsp valid cycle N+2.
REQ-024 Read following write to same address (back-to-back, any port) SHALL return new data; write commits at end of its ACCESS cycle.
REQ-025 Responses SHALL return in acceptance order; rsp0_valid and rsp1_valid never high in same cycle.

Reset
REQ-026 rst_n low SHALL immediately clear: state IDLE, cmd valid 0, mem_w_en 0, readyi 0, rspi_valid 0, rspi_rdata 0, last_grant = port 1 (port 0 wins first tie).
REQ-027 Reset during ACCESS SHALL drop the in-flight command: no write committed, no response issued.
REQ-028 First acceptance SHALL be possible on the first posedge after rst_n deasserts.

Structure
REQ-029 Port-index encoding and FSM state encodings SHALL live in shared constants file constants.v alongside `DATA_WORD_SIZE/`DATA_ADDR_SIZE.
REQ-030 One sub-module rr_arbiter2 (2-way round-robin grant from valids + last_grant) SHALL be used; memory bank stays external.

Verification
REQ-031 Single read: preload bank[5]=0x2A, req0 read addr 5 at cycle N -> rsp0_valid at N+2, rsp0_rdata=0x2A, rsp1_valid stays 0.
REQ-032 Contention: both valid continuously after reset, port0 addr 1, port1 addr 2 -> grants alternate 0,1,0,1; responses alternate 0,1 with one per cycle.
REQ-033 RAW: req1 write addr 3 data 0x55 at N, req0 read addr 3 at N+1 -> rsp0_rdata=0x55 at N+3.
REQ-034 Write only: req0 write addr 7 data 0x11 -> no rsp pulse; bank[7]=0x11 after N+1 edge.
REQ-035 Reset mid-op: accept write addr 9 data 0xFF, assert rst_n low in ACCESS before edge -> mem_w_en 0 immediately, bank[9] unchanged, all outputs at reset values.
REQ-036 Idle: no valids for 10 cycles -> mem_w_en 0, readyi 0, rspi_valid 0, last_grant unchanged.
